// File: rtl/inst_encoder.sv
// RV32I instruction-word assembler with LI expansion.
// One-word output register, valid/ready on request and output sides.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        HOLD_FIRST
    } state_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    state_t      state;
    logic [31:0] pend;

    logic [31:0] enc_inst;
    logic [31:0] enc_pend;
    logic        enc_last;
    logic        enc_err;
    logic        enc_has_pend;
    logic        fit12;
    logic        fit13;
    logic        fit21;
    logic [19:0] hi;

    assign req_ready = !out_valid || (out_ready && out_last);

    always_comb begin
        fit12 = (&req_imm[31:11]) || !(|req_imm[31:11]);
        fit13 = (&req_imm[31:12]) || !(|req_imm[31:12]);
        fit21 = (&req_imm[31:20]) || !(|req_imm[31:20]);
        // (imm + 0x800) >> 12 without carrying the unused low bits around
        hi = req_imm[31:12] + {19'd0, req_imm[11]};

        enc_inst     = 32'd0;
        enc_pend     = 32'd0;
        enc_last     = 1'b1;
        enc_err      = 1'b0;
        enc_has_pend = 1'b0;

        case (req_fmt)
            3'd0: begin
                enc_inst = {req_imm[11:0], req_rs1, req_funct3,
                            req_rd, req_opcode};
                enc_err  = !fit12;
            end
            3'd1: begin
                enc_inst = {req_funct7, req_imm[4:0], req_rs1,
                            req_funct3, req_rd, req_opcode};
                enc_err  = |req_imm[31:5];
            end
            3'd2: begin
                enc_inst = {req_imm[11:5], req_rs2, req_rs1,
                            req_funct3, req_imm[4:0], req_opcode};
                enc_err  = !fit12;
            end
            3'd3: begin
                enc_inst = {req_imm[12], req_imm[10:5], req_rs2,
                            req_rs1, req_funct3, req_imm[4:1],
                            req_imm[11], req_opcode};
                enc_err  = !fit13 || req_imm[0];
            end
            3'd4: begin
                enc_inst = {req_imm[20], req_imm[10:1], req_imm[11],
                            req_imm[19:12], req_rd, req_opcode};
                enc_err  = !fit21 || req_imm[0];
            end
            3'd5: begin
                if (fit12) begin
                    enc_inst = {req_imm[11:0], 5'd0, 3'b000,
                                req_rd, OP_IMM};
                end else begin
                    enc_inst = {hi, req_rd, OP_LUI};
                    if (|req_imm[11:0]) begin
                        enc_last     = 1'b0;
                        enc_has_pend = 1'b1;
                        enc_pend     = {req_imm[11:0], req_rd, 3'b000,
                                        req_rd, OP_IMM};
                    end
                end
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            pend      <= 32'd0;
        end else if (req_valid && req_ready) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_last  <= enc_last;
            out_err   <= enc_err;
            pend      <= enc_pend;
            state     <= enc_has_pend ? HOLD_FIRST : HOLD;
        end else if (out_valid && out_ready) begin
            if (state == HOLD_FIRST) begin
                out_inst <= pend;
                out_last <= 1'b1;
                out_err  <= 1'b0;
                pend     <= 32'd0;
                state    <= HOLD;
            end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Instruction-word assembler, the inverse of the core's immediate generator: takes a format tag, register fields, funct fields and a 32-bit immediate, and packs them into RV32I instruction words. Expands the LI pseudo-instruction into LUI+ADDI when the value does not fit 12 bits. Sits between the self-test/boot sequencer and instruction memory write port, with valid/ready on both sides and a one-word output register.

Parameters:
(none)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_fmt  input  3  0=I, 1=I-shift, 2=S, 3=B, 4=J, 5=LI; 6,7 reserved
req_opcode  input  7  opcode for fmt 0-4; ignored for LI
req_funct3  input  3  funct3 for fmt 0-3
req_funct7  input  7  funct7 for fmt 1 (bits 31:25)
req_rd  input  5  destination register (I, I-shift, J, LI)
req_rs1  input  5  source 1 (I, I-shift, S, B)
req_rs2  input  5  source 2 (S, B)
req_imm  input  32  immediate, two's complement
out_valid  output  1  out_inst valid
out_ready  input  1  consumer accepts when out_valid && out_ready
out_inst  output  32  encoded instruction
out_last  output  1  final word of the current request
out_err  output  1  immediate out of range or misaligned for this format

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, out_inst=0, out_last=0, out_err=0, state=IDLE, pending-word register cleared. Reset overrides everything, including a mid-LI expansion; the second word is discarded.
- FSM: IDLE (output register empty), HOLD (word presented, last), HOLD_FIRST (LUI presented, ADDI pending).
- req_ready = !out_valid || (out_ready && out_last). Throughput of one word/cycle for single-word formats.
- Latency: request accepted at edge N -> out_valid=1 with encoded word after edge N. No combinational path from req_* to out_*.
- Output stable: while out_valid && !out_ready, out_inst/out_last/out_err hold.
- HOLD_FIRST: on out_ready, load pending ADDI, out_last=1 -> HOLD. Requests are not accepted during this handoff.
- Simultaneous output handshake with last word and new request: new word loaded in the same edge; out_valid stays 1.
- Encodings (fields truncated to width):
  I: imm[11:0],rs1,f3,rd,op
  I-shift: funct7,imm[4:0],rs1,f3,rd,op
  S: imm[11:5],rs2,rs1,f3,imm[4:0],op
  B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op
  J: imm[20],imm[10:1],imm[11],imm[19:12],rd,op
- LI: if imm in [-2048,2047]: single ADDI rd,x0,imm (op 0010011, f3 000), out_last=1.
  Otherwise: hi=(imm+0x800)>>12 (32-bit wrap, logical shift, 20 bits); first word LUI rd,hi (op 0110111), out_last=0.
  If imm[11:0]!=0: second word ADDI rd,rd,imm[11:0], out_last=1. If imm[11:0]==0: LUI only, out_last=1.
  LI never sets out_err.
- out_err range rules; the word is still emitted truncated:
  I,S: imm outside [-2048,2047]
  I-shift: imm[31:5]!=0
  B: outside [-4096,4094] or imm[0]=1
  J: outside [-1048576,1048574] or imm[0]=1
  fmt 6/7: out_inst=0, out_err=1, out_last=1.

Test Plan:
- I: fmt0 op=0010011 f3=0 rd=5 rs1=6 imm=0xFFFFFFFF -> one cycle later out_inst=0xFFF30293, out_last=1, out_err=0.
- B/J: fmt3 op=1100011 f3=0 rs1=1 rs2=2 imm=8 -> 0x00208463; fmt4 op=1101111 rd=1 imm=0xFFFFFFFC -> 0xFFDFF0EF; back-to-back with out_ready=1 -> consecutive cycles, no bubble.
- LI: rd=10 imm=0x12345FFF -> 0x12346537 (last=0), then 0xFFF50513 (last=1), req_ready low until the second word is taken. imm=0x00001000 -> 0x00001537 only (last=1). imm=-5 -> 0xFFB00513 only.
- Errors: fmt3 imm=3 -> out_err=1; fmt2 imm=2048 -> out_err=1; fmt1 imm=32 -> out_err=1; fmt7 -> out_inst=0, out_err=1.
- Backpressure: hold out_ready=0 for 3 cycles on any word -> out_inst/out_last/out_err unchanged, req_ready=0, no request consumed.
- Reset mid-LI: rst_n=0 while LUI presented -> next cycle out_valid=0, out_inst=0; after release the ADDI never appears and req_ready=1.
